// File: rtl/blake2_io_pkg.sv
// Shared definitions for the BLAKE2 byte-serial command interface:
// command codes, framing sizes and the transmitter state encoding.
package blake2_io_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int CONF_BYTES  = 10;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONF,
        ST_KEY,
        ST_MSG,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/blake2_tx_blockcnt.sv
// Block bookkeeping for the transmitter: position inside the current
// 64-byte block, remaining message bytes, final-block flag and padding select.
module blake2_tx_blockcnt
    import blake2_io_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        init,
    input  logic [63:0] ll,
    input  logic        advance,
    input  logic        in_key,
    input  logic [5:0]  kk,
    output logic        last,
    output logic        pad,
    output logic        block_end
);

    logic [5:0]  byte_cnt_reg;
    logic [63:0] rem_reg;
    logic        last_reg;

    // At byte 0 the final-block decision is taken live; it is held for the
    // remaining 63 bytes because rem keeps moving inside the block.
    // While in the key block rem still equals ll, so rem==0 means ll==0.
    assign last      = (byte_cnt_reg == 6'd0)
                     ? (in_key ? (rem_reg == 64'd0) : (rem_reg <= 64'(BLOCK_BYTES)))
                     : last_reg;
    assign pad       = in_key ? (byte_cnt_reg >= kk) : (rem_reg == 64'd0);
    assign block_end = (byte_cnt_reg == 6'(BLOCK_BYTES - 1));

    // Counters advance only when a data byte is actually staged.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            byte_cnt_reg <= 6'd0;
            rem_reg      <= 64'd0;
            last_reg     <= 1'b0;
        end else if (init) begin
            byte_cnt_reg <= 6'd0;
            rem_reg      <= ll;
            last_reg     <= 1'b0;
        end else if (advance) begin
            byte_cnt_reg <= byte_cnt_reg + 6'd1;
            if (byte_cnt_reg == 6'd0) begin
                last_reg <= last;
            end
            if (!in_key && !pad) begin
                rem_reg <= rem_reg - 64'd1;
            end
        end
    end

endmodule

// File: rtl/blake2_cmd_tx.sv
// Host-side byte-serial command transmitter for the BLAKE2 core: emits the
// configuration bytes, the optional zero-padded key block and the message
// blocks (final one zero-padded) as registered valid/cmd/data.
module blake2_cmd_tx
    import blake2_io_pkg::*;
(
    input  logic        clk,
    input  logic        nreset,
    input  logic        start_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        src_valid_i,
    input  logic [7:0]  src_data_i,
    output logic        src_ready_o,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o
);

    tx_state_t   state_reg, state_next;
    logic [5:0]  kk_reg, nn_reg;
    logic [63:0] ll_reg;
    logic [3:0]  conf_cnt_reg, conf_cnt_next;
    logic        valid_reg, valid_next;
    logic [1:0]  cmd_reg, cmd_next;
    logic [7:0]  data_reg, data_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        first_reg, first_next;

    logic        accept;
    logic        in_data, in_key, stage;
    logic        last, pad, block_end;
    logic [3:0]  ll_idx;
    logic [7:0]  conf_byte;

    assign accept  = (state_reg == ST_IDLE) && start_i;
    assign in_key  = (state_reg == ST_KEY);
    assign in_data = in_key || (state_reg == ST_MSG);
    // Padding bytes need only the core to be ready; source bytes need both.
    assign stage   = in_data && ready_i && (pad || src_valid_i);

    assign src_ready_o = ready_i && in_data && !pad;

    // Bytes 2..9 of the configuration are ll, least significant byte first.
    assign ll_idx    = conf_cnt_reg - 4'd2;
    assign conf_byte = (conf_cnt_reg == 4'd1) ? {2'b00, nn_reg}
                                              : ll_reg[{ll_idx[2:0], 3'b000} +: 8];

    blake2_tx_blockcnt u_blockcnt (
        .clk       (clk),
        .nreset    (nreset),
        .init      (accept),
        .ll        (ll_i),
        .advance   (stage),
        .in_key    (in_key),
        .kk        (kk_reg),
        .last      (last),
        .pad       (pad),
        .block_end (block_end)
    );

    // State, output and latched-parameter registers.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg    <= ST_IDLE;
            kk_reg       <= 6'd0;
            nn_reg       <= 6'd0;
            ll_reg       <= 64'd0;
            conf_cnt_reg <= 4'd0;
            valid_reg    <= 1'b0;
            cmd_reg      <= CMD_CONF;
            data_reg     <= 8'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            first_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            conf_cnt_reg <= conf_cnt_next;
            valid_reg    <= valid_next;
            cmd_reg      <= cmd_next;
            data_reg     <= data_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            first_reg    <= first_next;
            if (accept) begin
                kk_reg <= kk_i;
                nn_reg <= nn_i;
                ll_reg <= ll_i;
            end
        end
    end

    // Next-state and staged-byte selection.
    always_comb begin
        state_next    = state_reg;
        conf_cnt_next = conf_cnt_reg;
        valid_next    = 1'b0;
        cmd_next      = cmd_reg;
        data_next     = data_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        first_next    = first_reg;
        case (state_reg)
            ST_IDLE: begin
                // Configuration byte 0 (kk) is staged straight from the
                // inputs so it appears the cycle after start.
                if (start_i) begin
                    state_next    = ST_CONF;
                    busy_next     = 1'b1;
                    first_next    = 1'b1;
                    valid_next    = 1'b1;
                    cmd_next      = CMD_CONF;
                    data_next     = {2'b00, kk_i};
                    conf_cnt_next = 4'd1;
                end
            end
            ST_CONF: begin
                valid_next    = 1'b1;
                cmd_next      = CMD_CONF;
                data_next     = conf_byte;
                conf_cnt_next = conf_cnt_reg + 4'd1;
                if (conf_cnt_reg == 4'(CONF_BYTES - 1)) begin
                    conf_cnt_next = 4'd0;
                    state_next    = (kk_reg != 6'd0) ? ST_KEY : ST_MSG;
                end
            end
            ST_KEY, ST_MSG: begin
                if (stage) begin
                    valid_next = 1'b1;
                    data_next  = pad ? 8'd0 : src_data_i;
                    cmd_next   = first_reg ? CMD_START : (last ? CMD_LAST : CMD_DATA);
                    first_next = 1'b0;
                    if (block_end) begin
                        state_next = last ? ST_DONE : ST_MSG;
                    end
                end
            end
            ST_DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign valid_o = valid_reg;
    assign cmd_o   = cmd_reg;
    assign data_o  = data_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_blake2_cmd_tx.sv
// Directed bench for blake2_cmd_tx: captures every emitted command byte and
// checks hand-picked positions plus the full stream against a framing model.
module tb_blake2_cmd_tx;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start_i;
    logic [5:0]  kk_i, nn_i;
    logic [63:0] ll_i;
    logic        src_valid_i;
    logic [7:0]  src_data_i;
    logic        src_ready_o;
    logic        ready_i;
    logic        valid_o;
    logic [1:0]  cmd_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] src_mem [0:255];
    logic [1:0] cap_cmd [$];
    logic [7:0] cap_data [$];
    logic [1:0] exp_cmd [$];
    logic [7:0] exp_data [$];
    int done_cnt, src_rdy_cnt, pace_err;
    logic busy_at_done;

    always #5 clk = ~clk;

    blake2_cmd_tx dut (
        .clk         (clk),
        .nreset      (nreset),
        .start_i     (start_i),
        .kk_i        (kk_i),
        .nn_i        (nn_i),
        .ll_i        (ll_i),
        .src_valid_i (src_valid_i),
        .src_data_i  (src_data_i),
        .src_ready_o (src_ready_o),
        .ready_i     (ready_i),
        .valid_o     (valid_o),
        .cmd_o       (cmd_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic fill_src(input logic [7:0] base);
        for (int i = 0; i < 256; i++) src_mem[i] = 8'(base + 8'(i));
    endtask

    // Reference framing: conf bytes, optional key block, message blocks.
    task automatic build_exp(input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll);
        int nblk;
        exp_cmd.delete();
        exp_data.delete();
        exp_cmd.push_back(2'd0); exp_data.push_back({2'b00, kk});
        exp_cmd.push_back(2'd0); exp_data.push_back({2'b00, nn});
        for (int i = 0; i < 8; i++) begin
            exp_cmd.push_back(2'd0); exp_data.push_back(ll[8*i +: 8]);
        end
        if (kk != 0) begin
            for (int i = 0; i < 64; i++) begin
                exp_data.push_back((i < int'(kk)) ? src_mem[i] : 8'h00);
                exp_cmd.push_back((i == 0) ? 2'd1 : ((ll == 0) ? 2'd3 : 2'd2));
            end
        end
        nblk = (ll == 0) ? ((kk == 0) ? 1 : 0) : int'((ll + 63) / 64);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) begin
                exp_data.push_back((64'(b * 64 + i) < ll) ? src_mem[int'(kk) + b * 64 + i] : 8'h00);
                if (kk == 0 && b == 0 && i == 0) exp_cmd.push_back(2'd1);
                else if (b == nblk - 1)          exp_cmd.push_back(2'd3);
                else                             exp_cmd.push_back(2'd2);
            end
        end
    endtask

    // Runs one hash. ready_mode=1 toggles ready_i each cycle; stall_at>=0 drops
    // src_valid_i for 5 cycles at that source index; abort_at>=0 pulls nreset
    // as data byte abort_at appears; stray_start>=0 pulses start_i mid-hash.
    task automatic run_hash(input logic [5:0] kk, input logic [5:0] nn, input logic [63:0] ll,
                            input int ready_mode, input int stall_at, input int abort_at,
                            input int stray_start);
        int  src_idx = 0;
        int  stall_left = 0;
        bit  stalled_once = 0;
        bit  consume = 0;
        logic prev_ready = 1'b1;
        logic prev_srcv = 1'b1;
        cap_cmd.delete();
        cap_data.delete();
        done_cnt = 0; src_rdy_cnt = 0; pace_err = 0; busy_at_done = 1'b1;
        @(negedge clk);
        start_i = 1'b1; kk_i = kk; nn_i = nn; ll_i = ll;
        ready_i = 1'b1; src_valid_i = 1'b0; src_data_i = 8'h00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (consume) src_idx++;
            if (valid_o) begin
                cap_cmd.push_back(cmd_o);
                cap_data.push_back(data_o);
                if (cap_data.size() > 10 && !prev_ready) pace_err++;
                if (cap_data.size() > 10 && stall_at >= 0 && !prev_srcv) pace_err++;
            end
            if (done_o) begin
                done_cnt++;
                busy_at_done = busy_o;
                break;
            end
            if (abort_at >= 0 && cap_data.size() == 10 + abort_at + 1) begin
                nreset = 1'b0;
                break;
            end
            if (cyc == stray_start) begin
                start_i = 1'b1; kk_i = 6'd7; nn_i = 6'd1; ll_i = 64'd200;
            end else begin
                start_i = 1'b0;
            end
            ready_i = (ready_mode != 0) ? cyc[0] : 1'b1;
            if (stall_at >= 0 && src_idx == stall_at && !stalled_once) begin
                stalled_once = 1;
                stall_left = 5;
            end
            src_valid_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            src_data_i = src_mem[src_idx];
            #1;
            consume = src_ready_o && src_valid_i;
            if (src_ready_o) src_rdy_cnt++;
            prev_ready = ready_i;
            prev_srcv  = src_valid_i;
        end
        start_i = 1'b0;
    endtask

    task automatic check_stream(input string name);
        int first_bad = -1;
        for (int i = 0; i < exp_data.size() && i < cap_data.size(); i++) begin
            if (first_bad < 0 && (cap_data[i] !== exp_data[i] || cap_cmd[i] !== exp_cmd[i]))
                first_bad = i;
        end
        total++;
        if (cap_data.size() != exp_data.size() || first_bad >= 0) begin
            bad++;
            $display("FAIL %s stream: got %0d bytes first_diff=%0d, need %0d bytes", name,
                     cap_data.size(), first_bad, exp_data.size());
        end
    endtask

    task automatic check_done(input string name);
        total++;
        if (done_cnt !== 1 || busy_at_done !== 1'b0) begin
            bad++;
            $display("FAIL %s done: done_cnt=%0d busy_at_done=%b, need 1/0", name, done_cnt, busy_at_done);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; start_i = 1'b0; kk_i = 0; nn_i = 0; ll_i = 0;
        ready_i = 1'b1; src_valid_i = 1'b1; src_data_i = 8'hFF;
        repeat (3) @(negedge clk);
        total++; if (valid_o !== 1'b0)   begin bad++; $display("FAIL reset valid_o: got %b need 0", valid_o); end
        total++; if (cmd_o !== 2'd0)     begin bad++; $display("FAIL reset cmd_o: got %0d need 0", cmd_o); end
        total++; if (data_o !== 8'd0)    begin bad++; $display("FAIL reset data_o: got %h need 00", data_o); end
        total++; if (busy_o !== 1'b0)    begin bad++; $display("FAIL reset busy_o: got %b need 0", busy_o); end
        total++; if (done_o !== 1'b0)    begin bad++; $display("FAIL reset done_o: got %b need 0", done_o); end
        total++; if (src_ready_o !== 1'b0) begin bad++; $display("FAIL reset src_ready_o: got %b need 0", src_ready_o); end
        nreset = 1'b1;
        @(negedge clk);
        $display("test_reset checked");
    endtask

    task automatic test_short();
        logic [7:0] conf_exp [0:9] = '{8'h00, 8'h20, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        int nbad = 0;
        fill_src(8'h41);
        run_hash(6'd0, 6'd32, 64'd3, 0, -1, -1, -1);
        for (int i = 0; i < 10; i++) if (cap_data[i] !== conf_exp[i] || cap_cmd[i] !== 2'd0) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL short conf: got %0d wrong bytes need 0", nbad); end
        total++; if (cap_data.size() != 74) begin bad++; $display("FAIL short len: got %0d need 74", cap_data.size()); end
        total++; if (cap_data[10] !== 8'h41 || cap_cmd[10] !== 2'd1) begin bad++; $display("FAIL short byte0: got %h/%0d need 41/1", cap_data[10], cap_cmd[10]); end
        total++; if (cap_data[12] !== 8'h43 || cap_cmd[12] !== 2'd3) begin bad++; $display("FAIL short byte2: got %h/%0d need 43/3", cap_data[12], cap_cmd[12]); end
        total++; if (cap_data[13] !== 8'h00 || cap_cmd[13] !== 2'd3) begin bad++; $display("FAIL short pad: got %h/%0d need 00/3", cap_data[13], cap_cmd[13]); end
        total++; if (cap_cmd[73] !== 2'd3) begin bad++; $display("FAIL short byte63 cmd: got %0d need 3", cap_cmd[73]); end
        check_done("short");
        build_exp(6'd0, 6'd32, 64'd3);
        check_stream("short");
        $display("test_short: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_empty();
        fill_src(8'h55);
        run_hash(6'd0, 6'd16, 64'd0, 0, -1, -1, -1);
        total++; if (src_rdy_cnt != 0) begin bad++; $display("FAIL empty src_ready: got %0d cycles need 0", src_rdy_cnt); end
        total++; if (cap_data[10] !== 8'h00 || cap_cmd[10] !== 2'd1) begin bad++; $display("FAIL empty byte0: got %h/%0d need 00/1", cap_data[10], cap_cmd[10]); end
        check_done("empty");
        build_exp(6'd0, 6'd16, 64'd0);
        check_stream("empty");
        $display("test_empty: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_two_block();
        fill_src(8'h10);
        run_hash(6'd0, 6'd32, 64'd65, 0, -1, -1, -1);
        total++; if (cap_data.size() != 138) begin bad++; $display("FAIL two_block len: got %0d need 138", cap_data.size()); end
        total++; if (cap_cmd[73] !== 2'd2) begin bad++; $display("FAIL two_block blk0 end cmd: got %0d need 2", cap_cmd[73]); end
        total++; if (cap_data[74] !== 8'h50 || cap_cmd[74] !== 2'd3) begin bad++; $display("FAIL two_block blk1 byte0: got %h/%0d need 50/3", cap_data[74], cap_cmd[74]); end
        total++; if (cap_data[75] !== 8'h00) begin bad++; $display("FAIL two_block pad: got %h need 00", cap_data[75]); end
        check_done("two_block");
        build_exp(6'd0, 6'd32, 64'd65);
        check_stream("two_block");
        $display("test_two_block: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_key();
        fill_src(8'h80);
        run_hash(6'd16, 6'd32, 64'd64, 0, -1, -1, -1);
        total++; if (cap_data.size() != 138) begin bad++; $display("FAIL key len: got %0d need 138", cap_data.size()); end
        total++; if (cap_data[10] !== 8'h80 || cap_cmd[10] !== 2'd1) begin bad++; $display("FAIL key byte0: got %h/%0d need 80/1", cap_data[10], cap_cmd[10]); end
        total++; if (cap_data[26] !== 8'h00 || cap_cmd[26] !== 2'd2) begin bad++; $display("FAIL key pad: got %h/%0d need 00/2", cap_data[26], cap_cmd[26]); end
        total++; if (cap_data[74] !== 8'h90 || cap_cmd[74] !== 2'd3) begin bad++; $display("FAIL key msg byte0: got %h/%0d need 90/3", cap_data[74], cap_cmd[74]); end
        check_done("key");
        build_exp(6'd16, 6'd32, 64'd64);
        check_stream("key");
        $display("test_key: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_stall();
        fill_src(8'h01);
        run_hash(6'd0, 6'd32, 64'd70, 1, 20, -1, -1);
        total++; if (pace_err != 0) begin bad++; $display("FAIL stall pacing: got %0d bytes while stalled need 0", pace_err); end
        check_done("stall");
        build_exp(6'd0, 6'd32, 64'd70);
        check_stream("stall");
        $display("test_stall: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_start_ignored();
        fill_src(8'h21);
        run_hash(6'd0, 6'd20, 64'd3, 0, -1, -1, 5);
        check_done("start_busy");
        build_exp(6'd0, 6'd20, 64'd3);
        check_stream("start_busy");
        $display("test_start_ignored: %0d bytes captured", cap_data.size());
    endtask

    task automatic test_abort();
        logic [7:0] conf_exp [0:2] = '{8'h03, 8'h10, 8'h05};
        int nbad = 0;
        fill_src(8'h30);
        run_hash(6'd0, 6'd32, 64'd100, 0, -1, 20, -1);
        @(negedge clk);
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL abort valid_o: got %b need 0", valid_o); end
        total++; if (busy_o !== 1'b0)  begin bad++; $display("FAIL abort busy_o: got %b need 0", busy_o); end
        nreset = 1'b1;
        fill_src(8'hC0);
        run_hash(6'd3, 6'd16, 64'd5, 0, -1, -1, -1);
        for (int i = 0; i < 3; i++) if (cap_data[i] !== conf_exp[i] || cap_cmd[i] !== 2'd0) nbad++;
        total++; if (nbad != 0) begin bad++; $display("FAIL abort restart conf: got %0d wrong bytes need 0", nbad); end
        check_done("abort_restart");
        build_exp(6'd3, 6'd16, 64'd5);
        check_stream("abort_restart");
        $display("test_abort: restart %0d bytes captured", cap_data.size());
    endtask

    initial begin
        test_reset();
        test_short();
        test_empty();
        test_two_block();
        test_key();
        test_stall();
        test_start_ignored();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
